overcurrent_monitor: RTL and testbench
======================================

OVERCURRENT_MONITOR -- requirements
Module: overcurrent_monitor

Interface
REQ-001 Parameter BLANK_CYC, default 50, clk cycles of comparator blanking after each synced PWM rising edge.
REQ-002 Parameter DEBOUNCE_CYC, default 8, consecutive qualified high samples needed to trip; legal range 1..255.
REQ-003 Parameter COOLDOWN_CYC, default 1000000, clk cycles enables are held off after a trip; legal range 1..2^24-1.
REQ-004 Parameter MAX_RETRY, default 3, trips allowed before lockout; legal range 1..3.
REQ-005 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 comp_a, comp_b  input  1 each  asynchronous overcurrent comparators, high = over limit.
REQ-008 pwm_in  input  1  motor PWM from the PWM generator.
REQ-009 en_req  input  1  primary enable switch.
REQ-010 clear  input  1  fault-clear request, level-sampled.
REQ-011 en_a, en_b  output  1 each  H-bridge enables, registered.
REQ-012 fault_a, fault_b  output  1 each  sticky per-channel trip flags.
REQ-013 retry_cnt  output  2  trips since last clear.
REQ-014 lockout  output  1  high while in LOCKOUT.
REQ-015 state  output  2  IDLE=0, RUN=1, COOLDOWN=2, LOCKOUT=3, for the display.

Function
REQ-016 comp_a, comp_b and pwm_in SHALL each pass a 2-flop synchronizer; all logic uses the synced copies.
REQ-017 A synced pwm rising edge SHALL load the blank counter with BLANK_CYC; the counter decrements to 0 and saturates there.
REQ-018 A comparator sample is qualified only when synced pwm=1 and the blank counter is 0.
REQ-019 Each channel's debounce counter SHALL increment on a qualified high sample and clear to 0 on any non-qualified or low sample.
REQ-020 A channel trips in the cycle its debounce counter reaches DEBOUNCE_CYC; the counter then clears.
REQ-021 IDLE: en_a=en_b=0; go to RUN when en_req=1 and clear=0.
REQ-022 RUN: en_a=en_b=synced pwm, registered; pwm_in to en_x latency is 3 clk cycles; en_req=0 goes to IDLE.
REQ-023 A trip in RUN SHALL set the tripping channel's fault flag, increment retry_cnt, and drive en_a=en_b=0 from the next cycle.
REQ-024 On a trip, if the incremented retry_cnt equals MAX_RETRY, the next state is LOCKOUT; otherwise it is COOLDOWN with the cooldown counter loaded with COOLDOWN_CYC.
REQ-025 COOLDOWN: enables 0, comparators ignored, counter decrements; at 0, go to RUN if en_req=1, else IDLE.
REQ-026 LOCKOUT: enables 0; exit to IDLE only when clear=1 and en_req=0, clearing fault_a, fault_b and retry_cnt on that edge.
REQ-027 clear=1 in IDLE SHALL zero fault_a, fault_b and retry_cnt; clear in RUN or COOLDOWN SHALL be ignored.
REQ-028 Both channels tripping in the same cycle SHALL set both flags and increment retry_cnt once.
REQ-029 A trip and en_req falling in the same cycle: the trip wins.
REQ-030 Leaving RUN to IDLE via en_req SHALL NOT clear retry_cnt or the fault flags.

Reset
REQ-031 rst=1 SHALL force IDLE and zero all counters, synchronizers, en_a, en_b, fault_a, fault_b, retry_cnt and lockout, effective on the next clk edge, including mid-COOLDOWN and mid-debounce.

Configuration
REQ-032 With OCM_TRIP_COUNT_EN defined, output trip_count[15:0] SHALL exist, increment once per trip event (same-cycle dual trip counts 1), saturate at 65535, and clear only on rst.
REQ-033 Without OCM_TRIP_COUNT_EN, the trip_count port and its logic SHALL be absent and all other behaviour is unchanged.

Verification (bench parameters: BLANK_CYC=4, DEBOUNCE_CYC=3, COOLDOWN_CYC=20, MAX_RETRY=3)
REQ-034 en_req=1, pwm at 50%, comps low -> state=1, en_a/en_b track pwm_in delayed 3 cycles, faults stay 0.
REQ-035 comp_a held high through the whole PWM high phase -> no trip inside the 4-cycle blank window; trip 3 qualified cycles later; fault_a=1, retry_cnt=1, state=2, enables 0 for 20 cycles, then state=1.
REQ-036 comp_b 2-cycle glitch after blanking -> no trip; a 3-cycle pulse -> trip.
REQ-037 Three successive trips -> retry_cnt=3, lockout=1, state=3; clear=1 with en_req=1 has no effect; then en_req=0 with clear=1 -> state=0, flags and retry_cnt 0.
REQ-038 rst asserted mid-COOLDOWN -> next cycle state=0, all outputs 0; comp_a and comp_b tripping in the same cycle -> both flags set, retry_cnt +1, trip_count +1 when OCM_TRIP_COUNT_EN is defined.

Source files
------------

// File: rtl/overcurrent_monitor.sv
// Overcurrent monitor for a two-channel H-bridge.
// The comparators and the PWM are synchronized first. Comparator samples are
// blanked after each PWM rising edge and debounced. A trip forces the enables
// low and starts a cooldown. Repeated trips latch a lockout that only a
// clear request can release.
// Optional build macro: OCM_TRIP_COUNT_EN adds a saturating trip_count[15:0]
// output that only rst clears.
module overcurrent_monitor #(
    parameter int BLANK_CYC    = 50,
    parameter int DEBOUNCE_CYC = 8,
    parameter int COOLDOWN_CYC = 1000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        comp_a,
    input  logic        comp_b,
    input  logic        pwm_in,
    input  logic        en_req,
    input  logic        clear,
    output logic        en_a,
    output logic        en_b,
    output logic        fault_a,
    output logic        fault_b,
    output logic [1:0]  retry_cnt,
    output logic        lockout,
    output logic [1:0]  state
`ifdef OCM_TRIP_COUNT_EN
    ,
    output logic [15:0] trip_count
`endif
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;
    localparam logic [1:0] ST_LOCKOUT  = 2'd3;

    localparam logic [15:0] BLANK_LD = 16'(BLANK_CYC);
    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYC - 1);
    localparam logic [23:0] COOL_LD  = 24'(COOLDOWN_CYC);
    localparam logic [1:0]  MAX_RT   = 2'(MAX_RETRY);

    // Synchronizer stages: _p0 is the first flop, _p1 is the synced copy.
    // pwm_p2 holds the previous synced PWM for edge detection.
    logic comp_a_p0, comp_a_p1;
    logic comp_b_p0, comp_b_p1;
    logic pwm_p0, pwm_p1, pwm_p2;

    logic        pwm_rise;
    logic [15:0] blank_cnt;
    logic        qual;
    logic        hit_a, hit_b;
    logic        trip_a, trip_b, trip_any;
    logic [7:0]  deb_a, deb_b;

    logic [23:0] cd_cnt, cd_nxt, cd_dec;
    logic [1:0]  state_nxt;
    logic [1:0]  retry_nxt, retry_inc;
    logic        fa_nxt, fb_nxt;

    assign pwm_rise = pwm_p1 & ~pwm_p2;

    // Two-flop synchronizers for the asynchronous inputs, plus a PWM history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            comp_a_p0 <= 1'b0;
            comp_a_p1 <= 1'b0;
            comp_b_p0 <= 1'b0;
            comp_b_p1 <= 1'b0;
            pwm_p0    <= 1'b0;
            pwm_p1    <= 1'b0;
            pwm_p2    <= 1'b0;
        end else begin
            comp_a_p0 <= comp_a;
            comp_a_p1 <= comp_a_p0;
            comp_b_p0 <= comp_b;
            comp_b_p1 <= comp_b_p0;
            pwm_p0    <= pwm_in;
            pwm_p1    <= pwm_p0;
            pwm_p2    <= pwm_p1;
        end
    end

    // Blanking counter: reloads on each synced PWM rise, then counts down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_cnt <= '0;
        end else if (pwm_rise) begin
            blank_cnt <= BLANK_LD;
        end else if (blank_cnt != 16'd0) begin
            blank_cnt <= blank_cnt - 16'd1;
        end
    end

    // The edge cycle itself is blanked: the reloaded count is not visible until
    // the cycle after. Outside RUN the comparators are ignored.
    assign qual     = (state == ST_RUN) & pwm_p1 & ~pwm_rise & (blank_cnt == 16'd0);
    assign hit_a    = qual & comp_a_p1;
    assign hit_b    = qual & comp_b_p1;
    assign trip_a   = hit_a & (deb_a == DEB_LAST);
    assign trip_b   = hit_b & (deb_b == DEB_LAST);
    assign trip_any = trip_a | trip_b;

    // Debounce counters: count consecutive qualified highs, clear on trip or gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_a <= '0;
            deb_b <= '0;
        end else begin
            deb_a <= (hit_a && !trip_a) ? deb_a + 8'd1 : 8'd0;
            deb_b <= (hit_b && !trip_b) ? deb_b + 8'd1 : 8'd0;
        end
    end

    assign retry_inc = retry_cnt + 2'd1;
    assign cd_dec    = cd_cnt - 24'd1;

    // Next-state, retry and fault-flag decisions for the protection FSM.
    always_comb begin
        state_nxt = state;
        cd_nxt    = cd_cnt;
        retry_nxt = retry_cnt;
        fa_nxt    = fault_a;
        fb_nxt    = fault_b;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    fa_nxt    = 1'b0;
                    fb_nxt    = 1'b0;
                    retry_nxt = 2'd0;
                end else if (en_req) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A trip takes priority over en_req dropping in the same cycle.
                if (trip_any) begin
                    fa_nxt    = fault_a | trip_a;
                    fb_nxt    = fault_b | trip_b;
                    retry_nxt = retry_inc;
                    if (retry_inc == MAX_RT) begin
                        state_nxt = ST_LOCKOUT;
                    end else begin
                        state_nxt = ST_COOLDOWN;
                        cd_nxt    = COOL_LD;
                    end
                end else if (!en_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_COOLDOWN: begin
                // Exit on the cycle the count reaches zero, so COOLDOWN lasts
                // exactly COOLDOWN_CYC cycles.
                cd_nxt = cd_dec;
                if (cd_cnt <= 24'd1) begin
                    state_nxt = en_req ? ST_RUN : ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (clear && !en_req) begin
                    fa_nxt    = 1'b0;
                    fb_nxt    = 1'b0;
                    retry_nxt = 2'd0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Protection FSM registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cd_cnt    <= '0;
            retry_cnt <= 2'd0;
            fault_a   <= 1'b0;
            fault_b   <= 1'b0;
            lockout   <= 1'b0;
            en_a      <= 1'b0;
            en_b      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cd_cnt    <= cd_nxt;
            retry_cnt <= retry_nxt;
            fault_a   <= fa_nxt;
            fault_b   <= fb_nxt;
            lockout   <= (state_nxt == ST_LOCKOUT);
            // Enables follow the synced PWM only while the machine stays in RUN.
            en_a      <= (state_nxt == ST_RUN) & pwm_p1;
            en_b      <= (state_nxt == ST_RUN) & pwm_p1;
        end
    end

`ifdef OCM_TRIP_COUNT_EN
    // Lifetime trip-event counter: a dual-channel trip counts once, and the
    // counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            trip_count <= '0;
        end else if ((state == ST_RUN) && trip_any && (trip_count != 16'hFFFF)) begin
            trip_count <= trip_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_overcurrent_monitor.sv
// Scoreboard bench for overcurrent_monitor. A reference model predicts every
// cycle's outputs into a queue, and a monitor compares them on the falling edge.
`timescale 1ns/1ps
module tb_overcurrent_monitor;

    localparam int BLANK = 4;
    localparam int DEB   = 3;
    localparam int COOL  = 20;
    localparam int MAXR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic comp_a = 1'b0, comp_b = 1'b0, pwm_in = 1'b0, en_req = 1'b0, clear = 1'b0;
    logic en_a, en_b, fault_a, fault_b, lockout;
    logic [1:0] retry_cnt, state;
    logic [15:0] tc_act;
`ifdef OCM_TRIP_COUNT_EN
    logic [15:0] trip_count;
    assign tc_act = trip_count;
`else
    assign tc_act = 16'd0;
`endif

    int tests = 0;
    int fails = 0;
    int ph = 0;
    int pwm_hi = 10;

    always #5 clk = ~clk;

    overcurrent_monitor #(
        .BLANK_CYC(BLANK), .DEBOUNCE_CYC(DEB), .COOLDOWN_CYC(COOL), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .comp_a(comp_a), .comp_b(comp_b), .pwm_in(pwm_in),
        .en_req(en_req), .clear(clear), .en_a(en_a), .en_b(en_b),
        .fault_a(fault_a), .fault_b(fault_b), .retry_cnt(retry_cnt),
        .lockout(lockout), .state(state)
`ifdef OCM_TRIP_COUNT_EN
        , .trip_count(trip_count)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Synced signals are the raw inputs seen two clock edges earlier. Blanking
    // is tracked as "cycles since the last synced PWM rise".
    bit hp[$], hca[$], hcb[$];
    int m_started = 0;
    int m_d, m_sa, m_sb, m_st, m_rc, m_cd, m_tc;
    bit m_fa, m_fb, m_en;
    logic [24:0] expq[$];

    task automatic model_step();
        bit ps, pp, as_, bs_, rise, qual, ta, tb;
        int nst;
        if (rst) begin
            m_started = 1;
            hp = '{0, 0, 0}; hca = '{0, 0, 0}; hcb = '{0, 0, 0};
            m_d = 1000; m_sa = 0; m_sb = 0; m_st = 0; m_rc = 0; m_cd = 0; m_tc = 0;
            m_fa = 0; m_fb = 0; m_en = 0;
        end else if (m_started != 0) begin
            ps = hp[1]; pp = hp[0]; as_ = hca[1]; bs_ = hcb[1];
            rise = ps && !pp;
            m_d  = rise ? 0 : ((m_d < 1000) ? m_d + 1 : m_d);
            qual = (m_st == 1) && ps && !rise && (m_d > BLANK);
            ta = 0; tb = 0;
            if (qual && as_) begin m_sa++; if (m_sa == DEB) begin ta = 1; m_sa = 0; end end
            else m_sa = 0;
            if (qual && bs_) begin m_sb++; if (m_sb == DEB) begin tb = 1; m_sb = 0; end end
            else m_sb = 0;
            nst = m_st;
            if (m_st == 0) begin
                if (clear) begin m_fa = 0; m_fb = 0; m_rc = 0; end
                else if (en_req) nst = 1;
            end else if (m_st == 1) begin
                if (ta || tb) begin
                    if (ta) m_fa = 1;
                    if (tb) m_fb = 1;
                    m_rc++;
                    if (m_tc < 65535) m_tc++;
                    if (m_rc == MAXR) nst = 3;
                    else begin nst = 2; m_cd = COOL; end
                end else if (!en_req) nst = 0;
            end else if (m_st == 2) begin
                m_cd--;
                if (m_cd == 0) nst = en_req ? 1 : 0;
            end else begin
                if (clear && !en_req) begin m_fa = 0; m_fb = 0; m_rc = 0; nst = 0; end
            end
            m_en = (nst == 1) ? ps : 1'b0;
            m_st = nst;
            hp.push_back(pwm_in);  void'(hp.pop_front());
            hca.push_back(comp_a); void'(hca.pop_front());
            hcb.push_back(comp_b); void'(hcb.pop_front());
        end
        if (m_started != 0) begin
`ifdef OCM_TRIP_COUNT_EN
            expq.push_back({2'(m_st), m_en, m_en, m_fa, m_fb, 2'(m_rc), (m_st == 3), 16'(m_tc)});
`else
            expq.push_back({2'(m_st), m_en, m_en, m_fa, m_fb, 2'(m_rc), (m_st == 3), 16'd0});
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare every predicted cycle on the falling edge.
    initial forever begin
        logic [24:0] e, a;
        @(negedge clk);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {state, en_a, en_b, fault_a, fault_b, retry_cnt, lockout, tc_act};
            check("cycle_outputs", int'(a), int'(e));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic ca, input logic cb);
        pwm_in = (ph < pwm_hi);
        comp_a = ca;
        comp_b = cb;
        ph = (ph == 19) ? 0 : ph + 1;
        @(posedge clk); #1;
    endtask

    task automatic align();
        while (ph != 0) drive(1'b0, 1'b0);
    endtask

    task automatic wait_cooldown(input string name);
        int n = 0;
        while (state == 2'd2 && n < 100) begin drive(1'b0, 1'b0); n++; end
        check(name, n, COOL);
    endtask

    initial begin
        int n;
        int tc0;
        bit ca, cb;
        bit hold_clear;

        // Reset
        repeat (3) drive(1'b0, 1'b0);
        check("reset_outputs", int'({state, en_a, en_b, fault_a, fault_b, retry_cnt, lockout}), 0);
        rst = 1'b0;

        // Normal run, comparators low
        en_req = 1'b1;
        repeat (60) drive(1'b0, 1'b0);
        check("run_state", int'(state), 1);
        check("run_faults", int'({fault_a, fault_b, retry_cnt}), 0);

        // comp_a high for the whole PWM high phase
        align();
        n = 0;
        while (state != 2'd2 && n < 60) begin drive(ph < pwm_hi, 1'b0); n++; end
        check("trip_a_state", int'(state), 2);
        check("trip_a_flags", int'({fault_a, fault_b}), 2);
        check("trip_a_retry", int'(retry_cnt), 1);
        check("trip_a_enables", int'({en_a, en_b}), 0);
        wait_cooldown("cooldown_len_a");
        check("after_cooldown_state", int'(state), 1);

        // comp_b: 2-cycle glitch after blanking, then a 3-cycle pulse
        align();
        repeat (20) drive(1'b0, 1'b0);
        repeat (20) drive(1'b0, (ph == 6 || ph == 7));
        repeat (2) drive(1'b0, 1'b0);
        check("glitch_no_trip", int'({state, retry_cnt, fault_b}), int'({2'd1, 2'd1, 1'b0}));
        align();
        n = 0;
        while (state != 2'd2 && n < 40) begin drive(1'b0, (ph >= 5 && ph <= 7)); n++; end
        check("pulse_trip_b", int'({state, fault_b, retry_cnt}), int'({2'd2, 1'b1, 2'd2}));
        wait_cooldown("cooldown_len_b");

        // Third trip leads to lockout
        align();
        n = 0;
        while (state != 2'd3 && n < 60) begin drive(ph < pwm_hi, 1'b0); n++; end
        check("lockout_state", int'({state, lockout, retry_cnt}), int'({2'd3, 1'b1, 2'd3}));
        check("lockout_flags", int'({fault_a, fault_b, en_a, en_b}), int'(4'b1100));
        clear = 1'b1;
        repeat (5) drive(1'b0, 1'b0);
        check("clear_with_en_ignored", int'({state, retry_cnt}), int'({2'd3, 2'd3}));
        en_req = 1'b0;
        drive(1'b0, 1'b0);
        check("lockout_exit", int'({state, fault_a, fault_b, retry_cnt, lockout}), 0);
        clear = 1'b0;
        en_req = 1'b1;
        repeat (5) drive(1'b0, 1'b0);
        check("rerun_state", int'(state), 1);

        // rst in the middle of COOLDOWN
        align();
        n = 0;
        while (state != 2'd2 && n < 60) begin drive(ph < pwm_hi, 1'b0); n++; end
        check("pre_rst_cooldown", int'(state), 2);
        repeat (5) drive(1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0);
        check("rst_mid_cooldown", int'({state, en_a, en_b, fault_a, fault_b, retry_cnt, lockout}), 0);
        check("rst_trip_count", int'(tc_act), 0);
        rst = 1'b0;
        repeat (5) drive(1'b0, 1'b0);

        // Both channels trip in the same cycle
        tc0 = int'(tc_act);
        align();
        n = 0;
        while (state != 2'd2 && n < 60) begin drive(ph < pwm_hi, ph < pwm_hi); n++; end
        check("dual_trip_flags", int'({state, fault_a, fault_b, retry_cnt}), int'({2'd2, 1'b1, 1'b1, 2'd1}));
`ifdef OCM_TRIP_COUNT_EN
        check("dual_trip_count", int'(tc_act), tc0 + 1);
`else
        check("dual_trip_count", int'(tc_act), tc0);
`endif
        wait_cooldown("cooldown_len_dual");

        // Randomized traffic
        ca = 0; cb = 0; hold_clear = 0;
        for (int i = 0; i < 1500; i++) begin
            if (ph == 0) pwm_hi = $urandom_range(3, 17);
            if ($urandom_range(0, 3) == 0) ca = ~ca;
            if ($urandom_range(0, 3) == 0) cb = ~cb;
            if ($urandom_range(0, 59) == 0) en_req = ~en_req;
            if ($urandom_range(0, 19) == 0) hold_clear = ~hold_clear;
            clear = hold_clear;
            rst = ($urandom_range(0, 399) == 0);
            drive(ca, cb);
        end
        rst = 1'b0;
        clear = 1'b0;
        repeat (4) drive(1'b0, 1'b0);

        n = 0;
        while (expq.size() > 0 && n < 10) begin @(negedge clk); #1; n++; end
        check("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
